gray_code_counter_4bit: RTL and testbench
=========================================

# gray_code_counter_4bit

Free-running 4-bit Gray-code counter: a single clocked block that steps through the 16-state reflected binary Gray sequence, changing exactly one output bit per clock. It serves as a glitch-safe position or pointer source, e.g. for clock-domain-crossing FIFO pointers or low-switching-activity sequencers. The Gray output is taken directly from flip-flops. A binary-equivalent view and a terminal-count flag are provided as side outputs.

## Interface
- No parameters; width fixed at 4 bits.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset; sampled only on rising clk edge; rst=0 resets, rst=1 runs.
- gray_count  output  4  current Gray-coded count, driven directly from registers.
- bin_count  output  4  binary equivalent of gray_count (same cycle).
- terminal_count  output  1  high while gray_count == 4'b1000 (last state before wrap).

## Operation
- State: 4-bit binary register b; gray_count register g.
- g = b ^ (b >> 1), but g is held in its own flops. It must not be a combinational decode at the port.
- Each rising clk with rst=1: b <= b + 1 (mod 16), g <= (b+1) ^ ((b+1) >> 1).
- Required sequence from reset: 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, then wrap to 0000.
- Wrap 1000 -> 0000 is also a single-bit change. The Hamming distance between consecutive gray_count values is exactly 1 for every step, including the wrap.
- bin_count = b; it always equals the Gray-to-binary decode of gray_count.
- terminal_count = (g == 4'b1000), i.e. b == 15. It is high for exactly one cycle in every 16 while running.
- No enable and no direction input; the counter advances every cycle out of reset.

## Timing
- Reset: on a rising edge with rst=0:
  - gray_count <= 0000
  - bin_count <= 0000
  - terminal_count low from then on
- Reset has priority over counting.
- Asserting rst mid-sequence takes effect at the next rising edge regardless of current state.
- Holding rst low for multiple cycles keeps the outputs at 0000.
- Before the first reset edge, outputs are undefined; no asynchronous clearing.
- Latency: the first rising edge with rst=1 moves gray_count 0000 -> 0001. Each later edge advances one state.
- Outputs change only just after rising clk edges and are stable through the whole cycle. A sample on the falling edge sees the settled value.
- Reset release is sampled synchronously. There is no partial step in the cycle rst is deasserted.

## Test plan
- Reset: hold rst=0 for 2 rising edges -> gray_count=0000, bin_count=0000, terminal_count=0.
- Full sequence: release rst, sample at each negedge for 16 cycles -> the exact 16-value sequence above. bin_count goes 0..15, and terminal_count=1 only at 1000.
- Gray property and wrap: run 40 cycles, compare each sample with the previous one -> popcount(prev ^ cur) == 1 every cycle, including 1000 -> 0000.
- Reset mid-run: drive rst=0 while gray_count=0110 -> 0000 on the next edge. Release -> 0001 on the following edge.
- Reset hold: keep rst=0 for 5 edges -> gray_count stays 0000 and terminal_count stays 0 throughout.
- Consistency: for 32 cycles, check bin_count == Gray-to-binary decode of gray_count -> always equal.

Source files
------------

// File: rtl/gray_code_counter_4bit.sv
// gray_code_counter_4bit
//   Free-running 4-bit reflected-binary Gray counter. Each clock exactly one
//   bit of gray_count changes, including on the wrap 1000 -> 0000, so the
//   value is safe to sample from another clock domain (e.g. FIFO pointers).
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   synchronous active-low reset (0 = clear, 1 = run)
//   gray_count     out  [3:0] Gray count, driven straight from flops
//   bin_count      out  [3:0] binary equivalent of gray_count
//   terminal_count out  high while gray_count == 1000 (last state before wrap)
module gray_code_counter_4bit (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] gray_count,
    output logic [3:0] bin_count,
    output logic       terminal_count
);

    logic [3:0] bin_q;
    logic [3:0] gray_q;
    logic [3:0] bin_next;

    assign bin_next = bin_q + 4'd1;

    // The Gray value gets its own register, loaded with the encode of the
    // *next* binary value, so the port never sees a combinational decode
    // (which could glitch across several bits between edges).
    always_ff @(posedge clk) begin
        if (!rst) begin
            bin_q  <= 4'b0000;
            gray_q <= 4'b0000;
        end else begin
            bin_q  <= bin_next;
            gray_q <= bin_next ^ (bin_next >> 1);
        end
    end

    assign gray_count     = gray_q;
    assign bin_count      = bin_q;
    assign terminal_count = (gray_q == 4'b1000);

endmodule

// File: tb/tb_gray_code_counter_4bit.sv
module tb_gray_code_counter_4bit;

    logic       clk;
    logic       rst;
    logic [3:0] gray_count;
    logic [3:0] bin_count;
    logic       terminal_count;

    gray_code_counter_4bit dut (
        .clk            (clk),
        .rst            (rst),
        .gray_count     (gray_count),
        .bin_count      (bin_count),
        .terminal_count (terminal_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] g;
        logic [3:0] b;
        logic       tc;
    } exp_t;

    localparam logic [3:0] SEQ [16] = '{
        4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
        4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000
    };

    exp_t       sb [$];
    logic [3:0] midx;
    logic [3:0] prev_g;
    bit         prev_valid;
    int         errors;
    int         checks;

    function automatic logic [3:0] g2b(input logic [3:0] g);
        logic [3:0] r;
        r[3] = g[3];
        r[2] = r[3] ^ g[2];
        r[1] = r[2] ^ g[1];
        r[0] = r[1] ^ g[0];
        return r;
    endfunction

    task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive rst for one edge, push the model's expectation at the edge,
    // then pop and compare on the following falling edge.
    task automatic step(input logic r, input string tag);
        exp_t e;
        exp_t got;
        int   hd;
        rst = r;
        @(posedge clk);
        if (!r) midx = 4'd0;
        else    midx = midx + 4'd1;
        e.g  = SEQ[midx];
        e.b  = midx;
        e.tc = (midx == 4'd15);
        sb.push_back(e);
        @(negedge clk);
        got = sb.pop_front();
        check4({tag, ".gray"}, gray_count, got.g);
        check4({tag, ".bin"},  bin_count,  got.b);
        check4({tag, ".tc"},   {3'b000, terminal_count}, {3'b000, got.tc});
        check4({tag, ".dec"},  g2b(gray_count), bin_count);
        if (r && prev_valid) begin
            hd = $countones(prev_g ^ gray_count);
            checks++;
            assert (hd === 1) else begin
                errors++;
                $error("FAIL %s.hamming: observed=%0d expected=1 (prev=%b cur=%b)",
                       tag, hd, prev_g, gray_count);
            end
        end
        prev_g     = gray_count;
        prev_valid = 1'b1;
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        midx       = 4'd0;
        prev_g     = 4'd0;
        prev_valid = 1'b0;
        rst        = 1'b0;

        // reset for two edges
        step(1'b0, "reset0");
        step(1'b0, "reset1");

        // full sequence plus wrap: 40 running cycles
        for (int i = 0; i < 40; i++) step(1'b1, "run");

        // advance to 0110, then reset mid-run
        while (midx != 4'd4) step(1'b1, "seek");
        check4("at_0110", gray_count, 4'b0110);
        step(1'b0, "midrst");
        step(1'b1, "release");

        // hold reset for five edges
        for (int i = 0; i < 5; i++) step(1'b0, "hold");

        // consistency run
        for (int i = 0; i < 32; i++) step(1'b1, "cons");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
